count_mode_decoder: RTL and testbench

- Receiving end of the 4-bit step/down counter: samples the counter's output bus every clock and recovers the counting mode (increment ±1 or ±2, up or down) that produced the sequence.
- Locks once the mode has repeated consistently for a programmable number of samples. Flags deviations and keeps a saturating error tally.
- Sits beside the counter in the lab top-level as a self-check monitor; its mode outputs are compared against the counter's step/down inputs.

---
 rtl/count_mode_decoder.sv | 119 +++++++++++
 tb/tb_count_mode_decoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_mode_decoder.sv
// Self-check monitor for the 4-bit step/down counter. It recovers the counting
// mode from successive samples, locks once that mode repeats, and tallies deviations.
module count_mode_decoder #(
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [3:0]       cnt_in,
  output logic             locked,
  output logic             step,
  output logic             down,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, PRIMED, TRACK, LOCKED} state_t;

  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t     state;
  logic [3:0] prev;
  logic [3:0] match;
  logic [1:0] cand;
  logic [3:0] delta;
  logic [1:0] mode;
  logic       valid;

  // mode is packed as {step, down}; deltas of 0 and 8 carry no direction and are rejected
  always_comb begin
    delta = cnt_in - prev;
    valid = 1'b1;
    mode  = 2'b00;
    case (delta)
      4'd1:    mode = 2'b00;
      4'd2:    mode = 2'b10;
      4'd15:   mode = 2'b01;
      4'd14:   mode = 2'b11;
      default: valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      prev    <= 4'd0;
      match   <= 4'd0;
      cand    <= 2'b00;
      locked  <= 1'b0;
      step    <= 1'b0;
      down    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= 1'b0;
      if (en) begin
        prev <= cnt_in;
        case (state)
          IDLE: state <= PRIMED;
          PRIMED: begin
            if (valid) begin
              cand  <= mode;
              match <= 4'd1;
              if (LOCK_N == 1) begin
                state         <= LOCKED;
                locked        <= 1'b1;
                {step, down}  <= mode;
              end else begin
                state <= TRACK;
              end
            end
          end
          TRACK: begin
            if (!valid) begin
              state <= PRIMED;
              match <= 4'd0;
            end else if (mode == cand) begin
              match <= match + 4'd1;
              if (match + 4'd1 == LOCK_CNT) begin
                state        <= LOCKED;
                locked       <= 1'b1;
                {step, down} <= cand;
              end
            end else begin
              cand  <= mode;
              match <= 4'd1;
            end
          end
          LOCKED: begin
            if (!(valid && mode == cand)) begin
              err    <= 1'b1;
              locked <= 1'b0;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
              if (valid) begin
                cand  <= mode;
                match <= 4'd1;
                // a single matching delta is enough to relock when LOCK_N is 1
                if (LOCK_N == 1) begin
                  locked       <= 1'b1;
                  {step, down} <= mode;
                end else begin
                  state <= TRACK;
                end
              end else begin
                state <= PRIMED;
                match <= 4'd0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_mode_decoder.sv
// Bench for count_mode_decoder: two instances (LOCK_N=3/ERR_W=4 and LOCK_N=1/ERR_W=2)
// checked against a run-length model of the recovered counting mode.
module tb_count_mode_decoder;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic [3:0] cnt0 = 4'd0, cnt1 = 4'd0;
  logic       locked0, step0, down0, err0;
  logic       locked1, step1, down1, err1;
  logic [3:0] errcnt0;
  logic [1:0] errcnt1;

  int nvec = 0;
  int miscompares = 0;

  // Model: the mode is locked whenever the current run of identical valid deltas is long enough
  int         lockN [2] = '{3, 1};
  int         errMax[2] = '{15, 3};
  bit         mHas  [2];
  int         mPrev [2];
  int         mRun  [2];
  logic [1:0] mMode [2];
  logic [1:0] mOut  [2];
  logic       mErr  [2];
  int         mErrCnt[2];

  count_mode_decoder #(.LOCK_N(3), .ERR_W(4)) dut0 (
    .clk(clk), .nrst(nrst), .en(en0), .cnt_in(cnt0),
    .locked(locked0), .step(step0), .down(down0), .err(err0), .err_cnt(errcnt0)
  );

  count_mode_decoder #(.LOCK_N(1), .ERR_W(2)) dut1 (
    .clk(clk), .nrst(nrst), .en(en1), .cnt_in(cnt1),
    .locked(locked1), .step(step1), .down(down1), .err(err1), .err_cnt(errcnt1)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      mHas[u] = 0; mPrev[u] = 0; mRun[u] = 0; mMode[u] = 2'b00;
      mOut[u] = 2'b00; mErr[u] = 1'b0; mErrCnt[u] = 0;
    end
  endtask

  task automatic modelStep(input int u, input logic e, input logic [3:0] c);
    int d, mag;
    bit valid, same, wasLocked;
    logic [1:0] mode;
    mErr[u] = 1'b0;
    if (!e) return;
    if (!mHas[u]) begin
      mHas[u] = 1;
      mPrev[u] = int'(c);
      return;
    end
    d = (int'(c) - mPrev[u] + 16) % 16;
    mPrev[u] = int'(c);
    mag = (d < 8) ? d : 16 - d;
    valid = (mag == 1) || (mag == 2);
    mode = {mag == 2, d > 8};
    wasLocked = mRun[u] >= lockN[u];
    same = valid && mRun[u] > 0 && mode == mMode[u];
    if (wasLocked && !same) begin
      mErr[u] = 1'b1;
      if (mErrCnt[u] < errMax[u]) mErrCnt[u]++;
    end
    if (same) mRun[u] = (mRun[u] < 100) ? mRun[u] + 1 : 100;
    else if (valid) begin mRun[u] = 1; mMode[u] = mode; end
    else mRun[u] = 0;
    if (mRun[u] >= lockN[u]) mOut[u] = mMode[u];
  endtask

  function automatic logic [7:0] expv(input int u);
    logic [3:0] ec;
    ec = 4'(mErrCnt[u]);
    return {mRun[u] >= lockN[u], mOut[u], mErr[u], ec};
  endfunction

  function automatic logic [7:0] obs(input int u);
    if (u == 0) return {locked0, step0, down0, err0, errcnt0};
    return {locked1, step1, down1, err1, 2'b00, errcnt1};
  endfunction

  // Drives one sample into instance u (the other instance sees en=0), then waits past the edge
  task automatic applyStimulus(input int u, input logic e, input logic [3:0] c);
    if (u == 0) begin en0 = e; cnt0 = c; en1 = 1'b0; end
    else begin en1 = e; cnt1 = c; en0 = 1'b0; end
    @(posedge clk);
    modelStep(u, e, c);
    modelStep(1 - u, 1'b0, 4'd0);
    #1;
  endtask

  task automatic doReset();
    en0 = 1'b0; en1 = 1'b0;
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    modelReset();
    #3;
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if (obs(u) !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_hold dut%0d: got %b expected %b", u, obs(u), 8'h00);
      end
    end
    #9;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if (obs(u) !== expv(u)) begin
        miscompares++;
        $display("[TB] FAIL reset_release dut%0d: got %b expected %b", u, obs(u), expv(u));
      end
    end
  endtask

  task automatic test_lock_up();
    int seq[5] = '{0, 1, 2, 3, 4};
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 4'(seq[i]));
      nvec++;
      if (obs(0) !== expv(0)) begin
        miscompares++;
        $display("[TB] FAIL lock_up sample %0d: got %b expected %b", seq[i], obs(0), expv(0));
      end
      if (i >= 2) begin
        nvec++;
        if ({locked0, step0, down0, err0} !== {i >= 3, 3'b000}) begin
          miscompares++;
          $display("[TB] FAIL lock_up_point sample %0d: got %b expected %b",
                   seq[i], {locked0, step0, down0, err0}, {i >= 3, 3'b000});
        end
      end
    end
  endtask

  task automatic test_wrap_step2();
    int seq[5] = '{10, 12, 14, 0, 2};
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 4'(seq[i]));
      nvec++;
      if (obs(0) !== expv(0)) begin
        miscompares++;
        $display("[TB] FAIL wrap_step2 sample %0d: got %b expected %b", seq[i], obs(0), expv(0));
      end
    end
    nvec++;
    if ({locked0, step0, down0, err0, errcnt0} !== 8'b1100_0000) begin
      miscompares++;
      $display("[TB] FAIL wrap_step2_final: got %b expected %b",
               {locked0, step0, down0, err0, errcnt0}, 8'b1100_0000);
    end
  endtask

  task automatic test_mismatch_invalid();
    int seq[9] = '{5, 4, 3, 2, 5, 4, 3, 2, 1};
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1'b1, 4'(seq[i]));
      nvec++;
      if (obs(0) !== expv(0)) begin
        miscompares++;
        $display("[TB] FAIL mismatch sample %0d: got %b expected %b", seq[i], obs(0), expv(0));
      end
      if (i == 4) begin
        nvec++;
        if ({locked0, err0, errcnt0} !== 6'b01_0001) begin
          miscompares++;
          $display("[TB] FAIL mismatch_err: got %b expected %b", {locked0, err0, errcnt0}, 6'b01_0001);
        end
      end
    end
    nvec++;
    if ({locked0, step0, down0, err0, errcnt0} !== 8'b1010_0001) begin
      miscompares++;
      $display("[TB] FAIL mismatch_relock: got %b expected %b",
               {locked0, step0, down0, err0, errcnt0}, 8'b1010_0001);
    end
  endtask

  task automatic test_stall();
    doReset();
    for (int v = 6; v <= 9; v++) applyStimulus(0, 1'b1, 4'(v));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b0, 4'($urandom_range(0, 15)));
      nvec++;
      if (obs(0) !== expv(0)) begin
        miscompares++;
        $display("[TB] FAIL stall cycle %0d: got %b expected %b", i, obs(0), expv(0));
      end
    end
    applyStimulus(0, 1'b1, 4'd10);
    nvec++;
    if ({locked0, err0, errcnt0} !== 6'b10_0000) begin
      miscompares++;
      $display("[TB] FAIL stall_resume: got %b expected %b", {locked0, err0, errcnt0}, 6'b10_0000);
    end
  endtask

  task automatic test_mode_switch();
    int seq[8] = '{0, 1, 2, 3, 5, 7, 9, 11};
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b1, 4'(seq[i]));
      nvec++;
      if (obs(0) !== expv(0)) begin
        miscompares++;
        $display("[TB] FAIL mode_switch sample %0d: got %b expected %b", seq[i], obs(0), expv(0));
      end
      if (i == 6) begin
        nvec++;
        if ({locked0, step0, down0, err0, errcnt0} !== 8'b1100_0001) begin
          miscompares++;
          $display("[TB] FAIL mode_switch_relock: got %b expected %b",
                   {locked0, step0, down0, err0, errcnt0}, 8'b1100_0001);
        end
      end
    end
  endtask

  task automatic test_saturate();
    int seq[7]  = '{0, 1, 3, 2, 0, 1, 3};
    int ecnt[7] = '{0, 0, 1, 2, 3, 3, 3};
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1'b1, 4'(seq[i]));
      nvec++;
      if (obs(1) !== expv(1)) begin
        miscompares++;
        $display("[TB] FAIL saturate sample %0d: got %b expected %b", seq[i], obs(1), expv(1));
      end
      nvec++;
      if ({locked1, errcnt1} !== {i >= 1, 2'(ecnt[i])}) begin
        miscompares++;
        $display("[TB] FAIL saturate_count step %0d: got %b expected %b",
                 i, {locked1, errcnt1}, {i >= 1, 2'(ecnt[i])});
      end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1, 1'b1, 4'd5);
    #2;
    nrst = 1'b0;
    modelReset();
    #1;
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if (obs(u) !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL async_reset dut%0d: got %b expected %b", u, obs(u), 8'h00);
      end
    end
    #2;
    nrst = 1'b1;
    applyStimulus(1, 1'b1, 4'd6);
    applyStimulus(1, 1'b1, 4'd7);
    nvec++;
    if (obs(1) !== expv(1)) begin
      miscompares++;
      $display("[TB] FAIL async_reset_restart: got %b expected %b", obs(1), expv(1));
    end
  endtask

  // Mostly-coherent sequences with occasional mode changes, stalls and jumps
  task automatic test_random(input int u, input int n);
    int dl[4] = '{1, 2, 15, 14};
    int sel = 0;
    logic [3:0] cur = 4'($urandom_range(0, 15));
    logic e;
    doReset();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 14) == 0) sel = $urandom_range(0, 3);
      e = ($urandom_range(0, 7) != 0);
      if (e) begin
        if ($urandom_range(0, 11) == 0) cur = 4'($urandom_range(0, 15));
        else cur = cur + 4'(dl[sel]);
      end
      applyStimulus(u, e, e ? cur : 4'($urandom_range(0, 15)));
      nvec++;
      if (obs(u) !== expv(u)) begin
        miscompares++;
        $display("[TB] FAIL random dut%0d step %0d: got %b expected %b", u, i, obs(u), expv(u));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_wrap_step2();
    test_mismatch_invalid();
    test_stall();
    test_mode_switch();
    test_saturate();
    test_async_reset();
    test_random(0, 400);
    test_random(1, 300);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
